// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register plus req/ack instruction fetch into IR with misalignment/timeout fault.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [31:0] nextPC,
  input  logic        fetchStart,
  input  logic        flush,
  input  logic        imemAck,
  input  logic [31:0] imemRData,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  output logic [31:0] IR,
  output logic        irValid,
  output logic        busy,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir;
  logic [7:0]  r_cnt;
  logic        r_req, r_irv, r_fault;
  logic        w_open, w_pc_ld, w_bad, w_start, w_ack, w_tout;
  always_comb begin
    w_open  = r_state != REQ;
    w_pc_ld = w_open && PCWre && nextPC[1:0] == 2'b00;
    w_bad   = w_open && PCWre && nextPC[1:0] != 2'b00;
    w_start = w_open && fetchStart && !PCWre && !flush;
    w_ack   = !w_open && !flush && imemAck;
    w_tout  = !w_open && !flush && !imemAck && r_cnt == 8'(TIMEOUT - 1);
    w_next  = !w_open ? ((flush || w_tout) ? IDLE : w_ack ? HOLD : REQ) :
              w_start ? REQ :
              (r_state == HOLD && flush) ? IDLE : r_state;
  end
  // irValid is exactly "in HOLD" and imemReq is exactly "in REQ", registered alongside the state
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 32'h0;
      r_cnt   <= 8'h0;
      r_req   <= 1'b0;
      r_irv   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= w_next == REQ;
      r_irv   <= w_next == HOLD;
      r_cnt   <= w_open ? 8'h0 : r_cnt + 8'h1;
      r_fault <= r_fault || w_bad || w_tout;
      if (w_pc_ld) r_pc <= nextPC;
      if (w_ack) r_ir <= imemRData;
    end
  end
  assign PC       = r_pc;
  assign PC4      = r_pc + 32'd4;
  assign imemAddr = r_pc;
  assign imemReq  = r_req;
  assign IR       = r_ir;
  assign irValid  = r_irv;
  assign busy     = r_state == REQ;
  assign fault    = r_fault;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random checks of pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;
  localparam int TMO = 16;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b0;
  logic [31:0] nextPC = 32'h0;
  logic        fetchStart = 1'b0;
  logic        flush = 1'b0;
  logic        imemAck = 1'b0;
  logic [31:0] imemRData = 32'h0;
  logic [31:0] PC, PC4, imemAddr, IR;
  logic        imemReq, irValid, busy, fault;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ir = 32'h0;
  bit          m_fetch = 0;
  bit          m_irv = 0;
  bit          m_fault = 0;
  int          m_wait = 0;
  pc_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .nextPC(nextPC),
    .fetchStart(fetchStart), .flush(flush), .imemAck(imemAck), .imemRData(imemRData),
    .PC(PC), .PC4(PC4), .imemReq(imemReq), .imemAddr(imemAddr),
    .IR(IR), .irValid(irValid), .busy(busy), .fault(fault)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_fetch = 0; m_irv = 0; m_fault = 0; m_wait = 0;
  endtask
  task automatic model_edge();
    if (m_fetch) begin
      if (flush) begin m_fetch = 0; m_irv = 0; end
      else if (imemAck) begin m_ir = imemRData; m_irv = 1; m_fetch = 0; end
      else if (m_wait + 1 == TMO) begin m_fault = 1; m_fetch = 0; end
      else m_wait++;
    end else begin
      if (PCWre) begin
        if (nextPC % 4 == 0) m_pc = nextPC;
        else m_fault = 1;
      end else if (fetchStart && !flush) begin
        m_fetch = 1; m_wait = 0; m_irv = 0;
      end
      if (flush) m_irv = 0;
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".PC"}, PC, m_pc);
    check({tag, ".PC4"}, PC4, m_pc + 32'd4);
    check({tag, ".addr"}, imemAddr, m_pc);
    check({tag, ".req"}, 32'(imemReq), 32'(m_fetch));
    check({tag, ".busy"}, 32'(busy), 32'(m_fetch));
    check({tag, ".irValid"}, 32'(irValid), 32'(m_irv));
    check({tag, ".IR"}, IR, m_ir);
    check({tag, ".fault"}, 32'(fault), 32'(m_fault));
  endtask
  task automatic cyc(input string tag, input logic pw, input logic [31:0] np, input logic fs,
                     input logic fl, input logic ak, input logic [31:0] rd);
    PCWre = pw; nextPC = np; fetchStart = fs; flush = fl; imemAck = ak; imemRData = rd;
    @(posedge CLK);
    if (Reset) model_edge();
    #1;
    check_all(tag);
  endtask
  task automatic idle(input string tag);
    cyc(tag, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask
  int busy_cnt;
  logic [31:0] rnd_np;
  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #3 Reset = 1'b1;
    #1 check_all("reset");
    check("reset.PC4_const", PC4, 32'd4);
    cyc("pcw", 1, 32'h0040_0020, 0, 0, 0, 32'h0);
    check("pcw.PC4_const", PC4, 32'h0040_0024);
    busy_cnt = 0;
    cyc("fetch1", 0, 32'h0, 1, 0, 0, 32'h0);
    busy_cnt += int'(busy);
    for (int i = 0; i < 3; i++) begin
      idle("wait1");
      busy_cnt += int'(busy);
    end
    cyc("ack1", 0, 32'h0, 0, 0, 1, 32'h8C22_0004);
    busy_cnt += int'(busy);
    check("busy_cycles", 32'(busy_cnt), 32'd4);
    check("ir1_const", IR, 32'h8C22_0004);
    idle("hold1");
    cyc("mis", 1, 32'h0000_0006, 0, 0, 0, 32'h0);
    check("mis.PC_const", PC, 32'h0040_0020);
    cyc("fetch2", 0, 32'h0, 1, 0, 0, 32'h0);
    cyc("ack2", 0, 32'h0, 0, 0, 1, 32'h1234_5678);
    check("fault_sticky", 32'(fault), 32'd1);
    cyc("pc_hold", 1, 32'h0000_0040, 0, 0, 0, 32'h0);
    check("hold_pcw_irv", 32'(irValid), 32'd1);
    busy_cnt = 0;
    cyc("tmo_start", 0, 32'h0, 1, 0, 0, 32'h0);
    busy_cnt += int'(imemReq);
    for (int i = 0; i < 30; i++) begin
      cyc("tmo_wait", 1, 32'h0000_0080, 0, 0, 0, 32'h0);
      busy_cnt += int'(imemReq);
    end
    check("tmo_req_cycles", 32'(busy_cnt), 32'd16);
    check("tmo_irv", 32'(irValid), 32'd0);
    cyc("fetch3", 0, 32'h0, 1, 0, 0, 32'h0);
    cyc("ack3", 0, 32'h0, 0, 0, 1, 32'hCAFE_F00D);
    cyc("fetch4", 0, 32'h0, 1, 0, 0, 32'h0);
    cyc("flush_ack", 0, 32'h0, 0, 1, 1, 32'hDEAD_BEEF);
    check("flush.IR_const", IR, 32'hCAFE_F00D);
    check("flush.req", 32'(imemReq), 32'd0);
    cyc("ign_ack", 0, 32'h0, 0, 0, 1, 32'h5555_5555);
    cyc("pc_top", 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0);
    check("wrap.PC4", PC4, 32'h0);
    cyc("fs_pcw", 1, 32'h0000_0100, 1, 0, 0, 32'h0);
    check("fs_pcw.busy", 32'(busy), 32'd0);
    check("fs_pcw.PC", PC, 32'h0000_0100);
    cyc("fetch5", 0, 32'h0, 1, 0, 0, 32'h0);
    idle("mid_req");
    #2 Reset = 1'b0;
    #1 check("async_req", 32'(imemReq), 32'd0);
    model_reset();
    check_all("async_state");
    @(posedge CLK);
    #3 Reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rnd_np = $urandom;
      if ($urandom_range(0, 7) != 0) rnd_np[1:0] = 2'b00;
      cyc("rand", $urandom_range(0, 5) == 0, rnd_np, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC selection path in the multi-cycle CPU.
- Holds the architectural PC and accepts the selected next-PC when the controller asserts PCWre.
- On request, runs a req/ack read of instruction memory at PC and latches the returned word into the instruction register (IR) for the decode stage.
- Provides PC+4 back to the next-PC selection logic and flags misaligned targets and memory timeouts.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- TIMEOUT, 16, cycles the unit waits in REQ for imemAck before faulting (legal range 1..255).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PCWre  input  1  PC write enable from the controller.
- nextPC  input  32  selected next-PC value.
- fetchStart  input  1  one-cycle pulse: fetch the instruction at the current PC.
- flush  input  1  abort any in-flight fetch and invalidate IR.
- imemAck  input  1  instruction memory: data valid.
- imemRData  input  32  instruction memory read data.
- PC  output  32  current PC.
- PC4  output  32  PC+4, combinational.
- imemReq  output  1  instruction memory read request (registered).
- imemAddr  output  32  read address; equals PC.
- IR  output  32  latched instruction.
- irValid  output  1  IR holds a valid fetched word.
- busy  output  1  high in REQ state.
- fault  output  1  sticky error flag.

Behaviour:
- Reset (Reset=0, asynchronous):
  - PC=RESET_PC, IR=0, irValid=0, imemReq=0, fault=0, timeout counter=0, state=IDLE.
  - Takes effect immediately, including mid-fetch; imemReq drops without waiting for a clock edge.
- PC4 = PC + 32'd4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
- imemAddr = PC at all times.
- States: IDLE, REQ, HOLD. busy = (state==REQ).
- PC update:
  - Accepted only in IDLE or HOLD.
  - PCWre=1 with nextPC[1:0]==0: PC<=nextPC on the edge.
  - PCWre=1 with nextPC[1:0]!=0: PC is unchanged and fault<=1.
  - PCWre is ignored in REQ; PC is frozen while busy.
- IDLE/HOLD -> REQ:
  - Condition: fetchStart=1, PCWre=0, flush=0.
  - On that edge: imemReq<=1, irValid<=0, counter<=0.
  - If fetchStart and PCWre are both high, PCWre wins: PC updates, fetchStart is dropped, and the controller must re-pulse.
- REQ:
  - imemReq held at 1; the counter increments each cycle without ack.
  - imemAck=1 and flush=0: IR<=imemRData, irValid<=1, imemReq<=0, ->HOLD. Latency from fetchStart to irValid is 2 cycles with a zero-wait ack.
  - Counter reaches TIMEOUT-1 without ack: fault<=1, imemReq<=0, irValid stays 0, ->IDLE.
  - flush=1: imemReq<=0, irValid<=0, IR unchanged, ->IDLE. Flush wins over a simultaneous ack; that data is discarded.
- HOLD:
  - IR and irValid=1 are stable until the next fetch or a flush.
  - flush: irValid<=0, ->IDLE.
  - A PC update in HOLD leaves IR valid; it still reflects the old PC.
- fault is sticky and clears only on reset. The unit stays operational after a fault.
- imemAck outside REQ is ignored.

Test Plan:
- Reset release, RESET_PC=0 -> PC=0, PC4=4, imemReq=0, irValid=0, fault=0; assert Reset=0 mid-REQ -> imemReq=0 before the next edge.
- PCWre=1, nextPC=32'h00400020 -> PC=32'h00400020, PC4=32'h00400024; then fetchStart with ack after 3 wait cycles, imemRData=32'h8C220004 -> IR=32'h8C220004, irValid=1 on the edge after ack, busy high for 4 cycles.
- PCWre=1, nextPC=32'h00000006 -> PC unchanged, fault=1 and stays 1 through later successful fetches.
- fetchStart with no ack, TIMEOUT=16 -> imemReq high for exactly 16 cycles, then fault=1, state IDLE, irValid=0.
- flush asserted in the same cycle as imemAck with data 32'hDEADBEEF -> IR keeps its previous value, irValid=0, imemReq=0.
- PC=32'hFFFFFFFC -> PC4=0; fetchStart and PCWre together with nextPC=32'h100 -> PC=32'h100, no request issued, busy=0.
